// File: rtl/fpdiv_pkg.sv
// Shared types for the FP divider arbiter slice.
// Tag layout and widths used by the arbiter and its top.
package fpdiv_pkg;

   localparam int FP_W    = 32;
   localparam int MAX_REQ = 4;
   localparam int ID_W    = $clog2(MAX_REQ);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/fpdiv_rr_arbiter.sv
// Round-robin picker: first request at or after ptr, wrapping.
// Pure combinational; grant is one-hot or zero.
module fpdiv_rr_arbiter
   import fpdiv_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] winner
);

   int   idx;
   logic found;

   // scan NREQ positions starting at ptr, keep the first hit
   always_comb begin
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         for (int j = 0; j < NREQ; j++) begin
            if (!found && (j == idx) && req[j]) begin
               found    = 1'b1;
               grant[j] = 1'b1;
               winner   = ID_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/fpdivide_arbiter.sv
// Shares one pipelined FP divider between NREQ requesters.
// A tag pipe follows each op so its quotient returns to its owner.
module fpdivide_arbiter
   import fpdiv_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int DIV_LATENCY = 2,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [FP_W*NREQ-1:0] req_a,
   input  logic [FP_W*NREQ-1:0] req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [FP_W-1:0]      div_a,
   output logic [FP_W-1:0]      div_b,
   input  logic [FP_W-1:0]      div_result,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [FP_W-1:0]      rsp_data,
   output logic                 busy,
   output logic [CNT_W-1:0]     ops_done
);

   localparam int NSTG = DIV_LATENCY + 1;

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  winner;
   logic [ID_W-1:0]  nxt_ptr;
   logic [NREQ-1:0]  elig;
   logic [NREQ-1:0]  grant;
   logic             hs;
   logic [FP_W-1:0]  sel_a;
   logic [FP_W-1:0]  sel_b;
   tag_t [NSTG-1:0]  tag_q;
   tag_t             last;
   logic             inflight;

   assign elig = req_valid & {NREQ{en & ~reset}};

   fpdiv_rr_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .req   (elig),
      .ptr   (rr_ptr),
      .grant (grant),
      .winner(winner)
   );

   assign req_ready = grant;
   assign hs        = |grant;
   assign last      = tag_q[NSTG-1];
   assign nxt_ptr   = (winner == ID_W'(NREQ - 1)) ? '0
                                                  : winner + ID_W'(1);

   // route the winner's operand pair
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant[k]) begin
            sel_a = req_a[k*FP_W +: FP_W];
            sel_b = req_b[k*FP_W +: FP_W];
         end
      end
   end

   // anything still travelling through the divider
   always_comb begin
      inflight = 1'b0;
      for (int s = 0; s < NSTG; s++) begin
         inflight = inflight | tag_q[s].valid;
      end
   end

   assign busy = inflight | (|rsp_valid);

   // operand registers and rotating priority
   always_ff @(posedge clk) begin
      if (reset) begin
         div_a  <= '0;
         div_b  <= '0;
         rr_ptr <= '0;
      end else if (hs) begin
         div_a  <= sel_a;
         div_b  <= sel_b;
         rr_ptr <= nxt_ptr;
      end
   end

   // owner tags shift in lockstep with the divider pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q <= '0;
      end else begin
         tag_q[0].valid <= hs;
         tag_q[0].id    <= winner;
         for (int s = 1; s < NSTG; s++) begin
            tag_q[s] <= tag_q[s-1];
         end
      end
   end

   // capture quotient and pulse the owner
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
         ops_done  <= '0;
      end else begin
         rsp_valid <= '0;
         if (last.valid) begin
            rsp_data <= div_result;
            ops_done <= ops_done + CNT_W'(1);
            for (int k = 0; k < NREQ; k++) begin
               rsp_valid[k] <= (last.id == ID_W'(k));
            end
         end
      end
   end

endmodule

// File: tb/tb_fpdivide_arbiter.sv
// Scoreboard bench for fpdivide_arbiter with a 2-stage divider model.
// A narrow-counter twin instance exercises ops_done wrap.
module tb_fpdivide_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        en;
   logic [1:0]  req_valid;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [1:0]  req_ready;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_result;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic        busy;
   logic [15:0] ops_done;

   logic [1:0]  w_ready;
   logic [31:0] w_div_a;
   logic [31:0] w_div_b;
   logic [1:0]  w_rsp_valid;
   logic [31:0] w_rsp_data;
   logic        w_busy;
   logic [2:0]  w_ops_done;

   fpdivide_arbiter #(
      .NREQ(2), .DIV_LATENCY(2), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .en(en),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .div_a(div_a), .div_b(div_b),
      .div_result(div_result), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .busy(busy), .ops_done(ops_done)
   );

   fpdivide_arbiter #(
      .NREQ(2), .DIV_LATENCY(2), .CNT_W(3)
   ) u_wrap (
      .clk(clk), .reset(reset), .en(en),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(w_ready), .div_a(w_div_a), .div_b(w_div_b),
      .div_result(div_result), .rsp_valid(w_rsp_valid),
      .rsp_data(w_rsp_data), .busy(w_busy), .ops_done(w_ops_done)
   );

   // divider stand-in: quotient table, two register stages
   function automatic logic [31:0] quot(input logic [31:0] a,
                                        input logic [31:0] b);
      case ({a, b})
         64'h40400000_40000000: return 32'h3FC00000;
         64'h3F800000_00000000: return 32'h7F800000;
         64'h40C00000_40000000: return 32'h40400000;
         64'h3F800000_40000000: return 32'h3F000000;
         64'h41000000_40000000: return 32'h40800000;
         64'h40800000_40000000: return 32'h40000000;
         64'h40000000_40000000: return 32'h3F800000;
         64'h3F800000_40800000: return 32'h3E800000;
         64'h41100000_40400000: return 32'h40400000;
         64'h40A00000_40000000: return 32'h40200000;
         default:               return 32'h7FC00000;
      endcase
   endfunction

   logic [31:0] p1 = '0;
   logic [31:0] p2 = '0;
   always @(posedge clk) begin
      p1 <= quot(div_a, div_b);
      p2 <= p1;
   end
   assign div_result = p2;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] q;
      int          due;
   } exp_t;

   vec_t pend0[$];
   vec_t pend1[$];
   exp_t sb[$];
   int   glog[$];
   int   gcyc[$];
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_ops = 0;
   int   a0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic drive();
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      if (pend0.size() > 0) begin
         req_valid[0] = 1'b1;
         req_a[31:0]  = pend0[0].a;
         req_b[31:0]  = pend0[0].b;
      end
      if (pend1.size() > 0) begin
         req_valid[1] = 1'b1;
         req_a[63:32] = pend1[0].a;
         req_b[63:32] = pend1[0].b;
      end
   endtask

   task automatic cyc_go(input logic e);
      @(posedge clk);
      #1;
      en = e;
      drive();
   endtask

   task automatic drain(input string nm, input logic e);
      int k;
      k = 0;
      while ((sb.size() != 0 || pend0.size() != 0 || pend1.size() != 0)
             && k < 60) begin
         cyc_go(e);
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (sb.size() != 0 || pend0.size() != 0 || pend1.size() != 0) begin
         n_fail++;
         $display("FAIL %s_timeout: %0d rsp and %0d/%0d req still open, required 0",
                  nm, sb.size(), pend0.size(), pend1.size());
      end
   endtask

   // monitor: score responses, record handshakes as expectations
   always @(negedge clk) begin : mon
      exp_t e;
      vec_t v;
      if (!reset) begin
         if (rsp_valid != 2'b00) begin
            exp_ops++;
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected: rsp_valid=%b data=%h, required no rsp",
                        rsp_valid, rsp_data);
            end else begin
               e = sb.pop_front();
               if (rsp_valid !== 2'(1 << e.id) || rsp_data !== e.q ||
                   cyc != e.due || ops_done !== 16'(exp_ops) ||
                   w_ops_done !== 3'(exp_ops)) begin
                  n_fail++;
                  $display("FAIL rsp: got v=%b d=%h cyc=%0d ops=%0d wops=%0d, required v=%b d=%h cyc=%0d ops=%0d wops=%0d",
                           rsp_valid, rsp_data, cyc, ops_done, w_ops_done,
                           2'(1 << e.id), e.q, e.due, 16'(exp_ops),
                           3'(exp_ops));
               end
            end
         end
         if (req_ready != 2'b00) begin
            n_tests++;
            if (req_ready == 2'b11 || (req_ready & ~req_valid) != 2'b00) begin
               n_fail++;
               $display("FAIL ready_legal: ready=%b valid=%b, required one-hot within valid",
                        req_ready, req_valid);
            end
         end
         if (req_valid[0] && req_ready[0]) begin
            v = pend0.pop_front();
            sb.push_back('{0, v.q, cyc + 4});
            glog.push_back(0);
            gcyc.push_back(cyc);
         end
         if (req_valid[1] && req_ready[1]) begin
            v = pend1.pop_front();
            sb.push_back('{1, v.q, cyc + 4});
            glog.push_back(1);
            gcyc.push_back(cyc);
         end
      end
   end

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      drive();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_div_a", div_a, 32'h0);
      chk("rst_div_b", div_b, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_ops_done", 32'(ops_done), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      en    = 1'b1;

      // single op, 3.0 / 2.0
      pend0.push_back('{32'h40400000, 32'h40000000, 32'h3FC00000});
      drive();
      @(negedge clk);
      chk("t1_ready", 32'(req_ready), 32'h1);
      drain("t1", 1'b1);
      chk("t1_ops", 32'(ops_done), 32'd1);

      // lone requester wins even when the pointer favours the other
      pend0.push_back('{32'h40C00000, 32'h40000000, 32'h40400000});
      cyc_go(1'b1);
      @(negedge clk);
      chk("lone_req0", 32'(req_ready), 32'h1);
      drain("lone0", 1'b1);
      pend1.push_back('{32'h3F800000, 32'h40000000, 32'h3F000000});
      cyc_go(1'b1);
      @(negedge clk);
      chk("lone_req1", 32'(req_ready), 32'h2);
      drain("lone1", 1'b1);

      // contention: both requesters stream four ops each
      glog.delete();
      gcyc.delete();
      pend0.push_back('{32'h40C00000, 32'h40000000, 32'h40400000});
      pend0.push_back('{32'h41000000, 32'h40000000, 32'h40800000});
      pend0.push_back('{32'h40000000, 32'h40000000, 32'h3F800000});
      pend0.push_back('{32'h41100000, 32'h40400000, 32'h40400000});
      pend1.push_back('{32'h3F800000, 32'h40000000, 32'h3F000000});
      pend1.push_back('{32'h40800000, 32'h40000000, 32'h40000000});
      pend1.push_back('{32'h3F800000, 32'h40800000, 32'h3E800000});
      pend1.push_back('{32'h40A00000, 32'h40000000, 32'h40200000});
      drain("cont", 1'b1);
      chk("cont_grants", 32'(glog.size()), 32'd8);
      if (glog.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("cont_order%0d", i), 32'(glog[i]), 32'(i % 2));
         end
         chk("cont_back2back", 32'(gcyc[7] - gcyc[0]), 32'd7);
      end

      // en gating
      pend0.push_back('{32'h40800000, 32'h40000000, 32'h40000000});
      pend0.push_back('{32'h40000000, 32'h40000000, 32'h3F800000});
      pend0.push_back('{32'h41000000, 32'h40000000, 32'h40800000});
      repeat (5) begin
         cyc_go(1'b0);
         @(negedge clk);
         chk("en0_ready", 32'(req_ready), 32'h0);
         chk("en0_busy", 32'(busy), 32'h0);
      end
      cyc_go(1'b1);
      @(negedge clk);
      a0 = cyc;
      chk("en1_grant", 32'(req_ready), 32'h1);
      cyc_go(1'b1);
      @(negedge clk);
      chk("en1_grant2", 32'(req_ready), 32'h1);
      repeat (3) begin
         cyc_go(1'b0);
         @(negedge clk);
         chk("drop_ready", 32'(req_ready), 32'h0);
         chk("drop_busy", 32'(busy), 32'h1);
      end
      cyc_go(1'b0);
      @(negedge clk);
      chk("last_rsp_cyc", 32'(cyc - a0), 32'd5);
      chk("last_rsp", 32'(rsp_valid), 32'h1);
      chk("last_rsp_busy", 32'(busy), 32'h1);
      cyc_go(1'b0);
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_rsp", 32'(rsp_valid), 32'h0);
      drain("en_rest", 1'b1);

      // reset one cycle before the first response
      pend0.push_back('{32'h40C00000, 32'h40000000, 32'h40400000});
      pend0.push_back('{32'h41000000, 32'h40000000, 32'h40800000});
      pend0.push_back('{32'h40000000, 32'h40000000, 32'h3F800000});
      cyc_go(1'b1);
      cyc_go(1'b1);
      cyc_go(1'b1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      exp_ops = 0;
      drive();
      pend0.push_back('{32'h40400000, 32'h40000000, 32'h3FC00000});
      cyc_go(1'b1);
      @(negedge clk);
      chk("mid_rst_ready", 32'(req_ready), 32'h0);
      chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_ops", 32'(ops_done), 32'h0);
      chk("mid_rst_div_a", div_a, 32'h0);
      chk("mid_rst_data", rsp_data, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive();
      drain("post_rst", 1'b1);
      repeat (4) begin
         cyc_go(1'b1);
         @(negedge clk);
      end
      chk("post_rst_ops", 32'(ops_done), 32'd1);

      // special values pass through untouched
      pend1.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000});
      drain("special", 1'b1);
      chk("special_data", rsp_data, 32'h7F800000);

      // six more ops: narrow twin counter wraps 7 -> 0
      pend0.push_back('{32'h41100000, 32'h40400000, 32'h40400000});
      pend0.push_back('{32'h40A00000, 32'h40000000, 32'h40200000});
      pend0.push_back('{32'h3F800000, 32'h40800000, 32'h3E800000});
      pend1.push_back('{32'h40800000, 32'h40000000, 32'h40000000});
      pend1.push_back('{32'h40C00000, 32'h40000000, 32'h40400000});
      pend1.push_back('{32'h40400000, 32'h40000000, 32'h3FC00000});
      drain("wrap", 1'b1);
      cyc_go(1'b1);
      @(negedge clk);
      chk("final_ops", 32'(ops_done), 32'd8);
      chk("wrap_ops", 32'(w_ops_done), 32'd0);
      chk("final_busy", 32'(busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
